// File: rtl/serial_sub_amisha_if.sv
// Handshake and operand/result bundle for serial_sub_amisha.
// The master side (operand registers / bench) drives start and operands;
// the slave side (the subtractor) drives status and results.
// Handshake: start_amisha is a request that the subtractor samples only
// when it can accept (IDLE or DONE); busy_amisha marks the RUN window and
// done_amisha pulses for one cycle when diff/bout/v have just been updated.
interface serial_sub_amisha_if #(
    parameter int WIDTH = 8
);
    logic             start_amisha;
    logic [WIDTH-1:0] a_amisha;
    logic [WIDTH-1:0] b_amisha;
    logic             busy_amisha;
    logic             done_amisha;
    logic [WIDTH-1:0] diff_amisha;
    logic             bout_amisha;
    logic             v_amisha;
    // Debug view of the FSM state (0=IDLE, 1=RUN, 2=DONE)
    logic [1:0]       state_dbg;

    modport master (
        output start_amisha, a_amisha, b_amisha,
        input  busy_amisha, done_amisha, diff_amisha, bout_amisha, v_amisha,
        input  state_dbg
    );

    modport slave (
        input  start_amisha, a_amisha, b_amisha,
        output busy_amisha, done_amisha, diff_amisha, bout_amisha, v_amisha,
        output state_dbg
    );
endinterface

// File: rtl/serial_sub_amisha.sv
// Nibble-serial subtractor: computes a - b over WIDTH bits, one 4-bit slice
// per clock, least-significant slice first, with a registered borrow chain.
// Results (diff, unsigned borrow, signed overflow) are loaded together after
// the last slice, so partial slices are never visible on the outputs.
// Optional feature macro: SUB_SAT_EN -- when defined, a final borrow forces
// diff to all-zero (unsigned floor saturation); bout and v are unaffected.
module serial_sub_amisha #(
    parameter int WIDTH = 8
) (
    input  logic                clk_amisha,
    input  logic                rst_n_amisha,
    serial_sub_amisha_if.slave  bus
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] slices_q, slices_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sub5;
    logic [WIDTH-1:0] res_full;
    logic             last_slice;
    logic             can_accept;

    // Slice datapath: select the current nibble pair, subtract with borrow,
    // and form the full-width result with the fresh slice merged in.
    always_comb begin
        a_nib    = 4'h0;
        b_nib    = 4'h0;
        res_full = slices_q;
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        sub5 = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
                res_full[4*i +: 4] = sub5[3:0];
            end
        end
    end

    assign last_slice = (cnt_q == CW'(NIB - 1));
    assign can_accept = bus.start_amisha && (state_q != S_RUN);

    // Next-state and register-update logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        slices_d = slices_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        v_d      = v_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (can_accept) begin
                    a_d      = bus.a_amisha;
                    b_d      = bus.b_amisha;
                    slices_d = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                slices_d = res_full;
                borrow_d = sub5[4];
                if (last_slice) begin
`ifdef SUB_SAT_EN
                    diff_d = sub5[4] ? '0 : res_full;
`else
                    diff_d = res_full;
`endif
                    bout_d  = sub5[4];
                    v_d     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                              (res_full[WIDTH-1] ^ a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            slices_q <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            slices_q <= slices_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
        end
    end

    assign bus.busy_amisha = (state_q == S_RUN);
    assign bus.done_amisha = (state_q == S_DONE);
    assign bus.diff_amisha = diff_q;
    assign bus.bout_amisha = bout_q;
    assign bus.v_amisha    = v_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: doc/serial_sub_amisha.md
# serial_sub_amisha

Multi-cycle nibble-serial subtractor computing a − b over a WIDTH-bit operand pair, one 4-bit slice per clock with a registered borrow chain. It is the inverse-direction companion to the team's combinational 4/8-bit adder instances. It gives the datapath a small, handshaked difference unit (unsigned borrow plus signed overflow) instead of a full-width ripple subtractor. It sits beside the adder block and is driven by the same operand registers.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, ≥ 4; NIB = WIDTH/4 slices
- clk_amisha  input  1  rising-edge clock; the only clock
- rst_n_amisha  input  1  reset, asynchronous and active-low
- start_amisha  input  1  request; sampled only when the block can accept
- a_amisha  input  WIDTH  minuend, captured on the accepting edge
- b_amisha  input  WIDTH  subtrahend, captured on the accepting edge
- busy_amisha  output  1  high while state = RUN
- done_amisha  output  1  one-cycle completion pulse
- diff_amisha  output  WIDTH  result register, a − b mod 2^WIDTH
- bout_amisha  output  1  unsigned borrow out (1 when a < b)
- v_amisha  output  1  signed overflow of a − b (two's complement)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_amisha=1 → latch a, b; clear borrow and slice counter; go to RUN.
- RUN: each cycle, slice i = counter: {bo, d} = a[4i+3:4i] − b[4i+3:4i] − borrow (5-bit arithmetic; bo is the borrow bit). Write d into internal slice i; borrow ← bo; counter++.
- After slice NIB−1: load diff_amisha, bout_amisha (final borrow) and v_amisha together, then go to DONE.
- v_amisha = (a[MSB] ≠ b[MSB]) & (result[MSB] ≠ a[MSB]), using the wrapped (unsaturated) result.
- DONE: done_amisha=1 for this one cycle. Go to IDLE, or go directly to RUN if start_amisha=1 (back-to-back accept, new operands latched).
- start_amisha is ignored during RUN; the latched operands are unaffected by input changes after acceptance.
- Between completions, diff_amisha, bout_amisha and v_amisha hold their last values. Partial slices are never visible on the outputs.

## Timing
- Reset (asynchronous assert, any cycle) → state IDLE; busy, done, diff, bout and v all 0; borrow and counter 0.
- Reset mid-RUN aborts the operation: no done pulse, outputs 0. The first accept after deassertion behaves normally.
- Accept at edge k → busy high from k. Slices are computed at edges k+1 … k+NIB; result registers and DONE are entered at edge k+NIB.
- done_amisha is high for exactly cycle [k+NIB, k+NIB+1). For WIDTH=8, done is seen 2 cycles after the accepting edge.
- Throughput with back-to-back starts: one result per NIB+1 cycles.
- Wrap-around: counter stops at NIB−1 and never indexes past the operand.

## Configuration
- SUB_SAT_EN defined: when the final borrow = 1, diff_amisha loads all-zero (unsigned floor saturation). bout_amisha and v_amisha are unchanged from the wrapped computation.
- SUB_SAT_EN undefined: diff_amisha is always a − b mod 2^WIDTH.

## Test plan
- WIDTH=8, a=0xB3, b=0x00, start one cycle → 2 cycles later done=1 for one cycle; diff=0xB3, bout=0, v=0; busy high exactly during RUN.
- a=0x4C, b=0xA4 → diff=0xA8, bout=1, v=1. With SUB_SAT_EN: diff=0x00, bout=1, v=1.
- a=0x10, b=0x01 (cross-slice borrow) → diff=0x0F, bout=0, v=0. a=0xC3, b=0xC3 → diff=0x00, bout=0, v=0.
- a=0x80, b=0x01 → diff=0x7F, bout=0, v=1. Then a start pulse during RUN with a=0xFF, b=0x00 → ignored; result stays 0x7F.
- start held high across DONE with a=0x0F, b=0xF0 → second op accepted in the DONE cycle; next done exactly 3 cycles after the first; diff=0x1F, bout=1, v=0.
- rst_n_amisha pulsed low one cycle after accepting a=0x55, b=0x22 → all outputs 0 immediately, no done. A fresh start with a=0x55, b=0x22 then gives diff=0x33.
